// File: rtl/branch_pc_ctrl_pkg.sv
// branch_pc_ctrl_pkg: shared branch opcode, FSM state and PC increment definitions
package branch_pc_ctrl_pkg;
    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BLEZ = 3'd2;
    localparam logic [2:0] BR_BGTZ = 3'd3;
    localparam logic [2:0] BR_J    = 3'd4;
    localparam logic [2:0] BR_JR   = 3'd5;
    localparam logic [31:0] PC_INC = 32'd4;
    typedef enum logic [1:0] {ST_RUN, ST_SLOT, ST_PEND} state_e;
endpackage

// File: rtl/branch_pc_ctrl_if.sv
// branch_pc_ctrl_if: decode-to-PC-control branch handshake and operands
interface branch_pc_ctrl_if;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] bpc;
    logic [31:0] jpc;
    modport master(output br_valid, br_op, rs_val, rt_val, bpc, jpc, input br_ready);
    modport slave(input br_valid, br_op, rs_val, rt_val, bpc, jpc, output br_ready);
endinterface

// File: rtl/branch_pc_ctrl_cond.sv
// branch_cond_eval: combinational taken decision and raw target select
module branch_cond_eval
    import branch_pc_ctrl_pkg::*;
(
    input  logic [2:0]  br_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    output logic        taken,
    output logic [31:0] target
);
    // signed compares against zero reduce to sign bit and zero test
    always_comb begin
        taken  = br_op == BR_BEQ  ? rs_val == rt_val :
                 br_op == BR_BNE  ? rs_val != rt_val :
                 br_op == BR_BLEZ ? rs_val[31] | ~|rs_val :
                 br_op == BR_BGTZ ? ~rs_val[31] & |rs_val :
                 br_op == BR_J || br_op == BR_JR;
        target = br_op == BR_J ? jpc : br_op == BR_JR ? rs_val : bpc;
    end
endmodule

// File: rtl/branch_pc_ctrl.sv
// branch_pc_ctrl: fetch PC sequencing with branch redirect, delay slot and stats
module branch_pc_ctrl
    import branch_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b0,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_in,
    input  logic             clr_cnt,
    branch_pc_ctrl_if.slave  br,
    output logic [31:0]      pc_out,
    output logic             if_flush,
    output logic             br_misalign,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);
    state_e      state;
    logic [31:0] tgt_q;
    logic [31:0] target;
    logic [31:0] tgt_al;
    logic [31:0] pc_inc;
    logic        taken;
    logic        accept;
    logic        go;

    branch_cond_eval u_cond (
        .br_op  (br.br_op),
        .rs_val (br.rs_val),
        .rt_val (br.rt_val),
        .bpc    (br.bpc),
        .jpc    (br.jpc),
        .taken  (taken),
        .target (target)
    );

    assign br.br_ready = state == ST_RUN;
    assign accept      = br.br_valid & br.br_ready;
    assign go          = accept & taken;
    assign tgt_al      = {target[31:2], 2'b00};
    assign pc_inc      = pc_out + PC_INC;

    // PC/redirect FSM; pending target is parked in tgt_q while stalled or in the slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            pc_out      <= RESET_PC;
            tgt_q       <= '0;
            if_flush    <= 1'b0;
            br_misalign <= 1'b0;
        end else begin
            if_flush    <= 1'b0;
            br_misalign <= go & |target[1:0];
            case (state)
                ST_RUN: begin
                    if (go && stall_in) begin
                        tgt_q <= tgt_al;
                        state <= ST_PEND;
                    end else if (go && !DELAY_SLOT) begin
                        pc_out   <= tgt_al;
                        if_flush <= 1'b1;
                    end else if (go) begin
                        pc_out <= pc_inc;
                        tgt_q  <= tgt_al;
                        state  <= ST_SLOT;
                    end else if (!stall_in) begin
                        pc_out <= pc_inc;
                    end
                end
                ST_PEND: begin
                    if (!stall_in && DELAY_SLOT) begin
                        pc_out <= pc_inc;
                        state  <= ST_SLOT;
                    end else if (!stall_in) begin
                        pc_out   <= tgt_q;
                        if_flush <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_SLOT: begin
                    if (!stall_in) begin
                        pc_out <= tgt_q;
                        state  <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // saturating statistics; clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else if (clr_cnt) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else begin
            if (accept && ~&br_cnt) br_cnt <= br_cnt + CNT_W'(1);
            if (go && ~&taken_cnt) taken_cnt <= taken_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/branch_pc_ctrl.md
Name: branch_pc_ctrl

Overview:
- Sequences the fetch program counter for the MIPS pipeline.
- Evaluates branch/jump conditions from decode and selects the next PC: PC+4, the branch-adder result (bpc), the jump target, or the register target.
- Owns the PC register, IF flush pulse, optional delay-slot sequencing and branch statistics counters.
- Sits between the decode stage / branch target adder and the instruction-fetch stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DELAY_SLOT, 0, 1 = MIPS delay slot (one sequential fetch before redirect); 0 = immediate redirect with flush.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- stall_in  in  1  pipeline stall; PC holds while high.
- br_valid  in  1  decode presents a branch/jump.
- br_ready  out  1  = (state==RUN); branch accepted when br_valid & br_ready.
- br_op  in  3  0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 J, 5 JR, 6-7 reserved (never taken).
- rs_val  in  32  rs operand; also JR target.
- rt_val  in  32  rt operand.
- bpc  in  32  branch target from branch target adder (imm + PC+4).
- jpc  in  32  J-type target.
- clr_cnt  in  1  synchronous clear of both counters.
- pc_out  out  32  registered fetch PC.
- if_flush  out  1  registered one-cycle flush pulse for IF.
- br_misalign  out  1  registered one-cycle pulse: accepted taken target had [1:0]!=0.
- br_cnt  out  CNT_W  accepted branches, saturating.
- taken_cnt  out  CNT_W  accepted taken branches, saturating.

Behaviour:
- Reset (async, any state): pc_out=RESET_PC, state=RUN, tgt_q=0, if_flush=0, br_misalign=0, counters=0.
- All outputs are registered except br_ready, which is decoded from state.
- Taken condition:
  - BEQ: rs==rt.
  - BNE: rs!=rt.
  - BLEZ: signed rs<=0.
  - BGTZ: signed rs>0.
  - J and JR: always taken.
  - Reserved opcodes: not taken.
- Target: bpc for BEQ/BNE/BLEZ/BGTZ, jpc for J, rs_val for JR. Bits [1:0] are forced to 0 before loading. br_misalign pulses the cycle after acceptance if the original target had [1:0]!=0.
- PC+4 wraps modulo 2^32.
- States: RUN, SLOT, PEND.
- RUN, no accept: stall_in=1 → hold PC; else PC <= PC+4.
- RUN, accept not-taken: treated as no accept (PC+4 or hold).
- RUN, accept taken, stall_in=1: tgt_q <= target; go PEND; PC holds.
- RUN, accept taken, stall_in=0, DELAY_SLOT=0: PC <= target; if_flush=1 next cycle; stay RUN.
- RUN, accept taken, stall_in=0, DELAY_SLOT=1: PC <= PC+4; tgt_q <= target; go SLOT.
- PEND: hold while stall_in=1. On stall_in=0:
  - DELAY_SLOT=0: PC <= tgt_q, if_flush pulse, go RUN.
  - DELAY_SLOT=1: PC <= PC+4, go SLOT.
- SLOT: hold while stall_in=1. On stall_in=0: PC <= tgt_q, go RUN. if_flush is never asserted when DELAY_SLOT=1.
- br_valid is ignored in SLOT and PEND (br_ready=0); decode keeps it asserted until accepted.
- if_flush is high exactly in the first cycle pc_out shows the redirect target.
- Counters:
  - br_cnt increments on every accept; taken_cnt increments on accept & taken.
  - Both saturate at all-ones.
  - clr_cnt has priority over an increment in the same cycle.
- Reset asserted mid-SLOT/PEND discards tgt_q; the pending redirect is lost.

Decomposition:
- Shared package: br_op encodings (BR_BEQ..BR_JR), state encoding (ST_RUN/ST_SLOT/ST_PEND), PC_INC=32'd4.
- One sub-module, branch_cond_eval: combinational taken/target select from br_op, rs_val, rt_val, bpc, jpc.
- The FSM, PC register and counters stay in branch_pc_ctrl.

Test Plan:
- Reset, then 4 unstalled cycles → pc_out 0x0, 0x4, 0x8, 0xC; br_ready=1; if_flush=0; counters 0.
- DELAY_SLOT=0, pc=0x10, BEQ rs=rt=5, bpc=0x100, no stall → next pc=0x100, if_flush=1 for one cycle, br_cnt=1, taken_cnt=1.
- BNE with rs=rt=7 at pc=0x20 → pc=0x24, no flush, br_cnt+1, taken_cnt unchanged.
- stall_in=1 while JR rs=0x200 is accepted → br_ready=0, pc holds 2 stalled cycles; stall drops → pc=0x200, if_flush pulse, br_ready=1.
- DELAY_SLOT=1, J jpc=0x80 at pc=0x20 → pc 0x24 then 0x80; if_flush stays 0; stall inside SLOT holds 0x24.
- Boundary cases:
  - pc=0xFFFFFFFC unstalled → 0x0.
  - BEQ taken with bpc=0x102 → pc=0x100, br_misalign pulse.
  - CNT_W=4: 20 taken accepts → both counters at 15; clr_cnt with a simultaneous accept → 0.
